// File: rtl/con_pkg.sv
// Shared types and defaults for the up/down modulo counter.
package con_pkg;

  localparam int unsigned CON_W_DEF = 3;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } con_state_t;

endpackage

// File: rtl/con_updown_n_if.sv
// Control/data bundle for con_updown_n; gq exists only with CON_GRAY_OUT_EN.
interface con_updown_n_if import con_pkg::*; #(
  parameter int unsigned W = CON_W_DEF
) ();
  logic         x;
  logic         en;
  logic         ld;
  logic         os;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         tc;
  logic         wrap;
  logic         halted;
`ifdef CON_GRAY_OUT_EN
  logic [W-1:0] gq;
`endif

  modport master (
`ifdef CON_GRAY_OUT_EN
    input  gq,
`endif
    output x, en, ld, os, d,
    input  q, tc, wrap, halted
  );

  modport slave (
`ifdef CON_GRAY_OUT_EN
    output gq,
`endif
    input  x, en, ld, os, d,
    output q, tc, wrap, halted
  );
endinterface

// File: rtl/con_gray_enc.sv
// Binary to reflected-Gray encoder, combinational.
module con_gray_enc #(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0] i_bin,
  output logic [W-1:0] o_gray
);
  assign o_gray = i_bin ^ (i_bin >> 1);
endmodule

// File: rtl/con_updown_n.sv
// Up/down modulo-MODULO counter with load, free-run/one-shot modes.
// Optional Gray-coded output gq when CON_GRAY_OUT_EN is defined.
module con_updown_n import con_pkg::*; #(
  parameter int unsigned W      = CON_W_DEF,
  parameter int unsigned MODULO = 2**W
) (
  input logic          clk,
  input logic          res,
  con_updown_n_if.slave bus
);

  localparam logic [W:0] LP_MAX = (W+1)'(MODULO - 1);
  localparam logic [W:0] LP_ONE = (W+1)'(1);

  logic [W-1:0] r_q;
  logic [W-1:0] w_q_nxt;
  con_state_t   r_state;
  con_state_t   w_state_nxt;
  logic         r_wrap;
  logic         w_wrap_nxt;
  logic         w_tc;
  logic [W:0]   w_q_ext;
  logic [W:0]   w_d_ext;
  logic [W:0]   w_inc;
  logic [W:0]   w_dec;

  // One extra bit keeps the clamp compare and +/-1 free of overflow.
  assign w_q_ext = {1'b0, r_q};
  assign w_d_ext = {1'b0, bus.d};
  assign w_inc   = w_q_ext + LP_ONE;
  assign w_dec   = w_q_ext - LP_ONE;
  assign w_tc    = (bus.x && (w_q_ext == LP_MAX)) || (!bus.x && (r_q == '0));

  always_comb begin
    w_q_nxt     = r_q;
    w_state_nxt = r_state;
    w_wrap_nxt  = 1'b0;
    if (bus.ld) begin
      w_q_nxt     = (w_d_ext <= LP_MAX) ? bus.d : LP_MAX[W-1:0];
      w_state_nxt = RUN;
    end else if (bus.en && (r_state == RUN)) begin
      if (w_tc) begin
        w_wrap_nxt = 1'b1;
        if (bus.os) begin
          w_state_nxt = HALT;
        end else begin
          w_q_nxt = bus.x ? '0 : LP_MAX[W-1:0];
        end
      end else begin
        w_q_nxt = bus.x ? w_inc[W-1:0] : w_dec[W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_q     <= '0;
      r_state <= RUN;
      r_wrap  <= 1'b0;
    end else begin
      r_q     <= w_q_nxt;
      r_state <= w_state_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign bus.q      = r_q;
  assign bus.tc     = w_tc;
  assign bus.wrap   = r_wrap;
  assign bus.halted = (r_state == HALT);

`ifdef CON_GRAY_OUT_EN
  con_gray_enc #(.W(W)) u_gray (
    .i_bin  (r_q),
    .o_gray (bus.gq)
  );
`endif

endmodule

// File: tb/tb_con_updown_n.sv
// Bench for con_updown_n: MODULO=8 and MODULO=6 instances share stimulus.
module tb_con_updown_n;
  import con_pkg::*;

  logic       clk = 1'b0;
  logic       res;
  logic       x, en, ld, os;
  logic [2:0] d;

  int errors = 0;
  int checks = 0;

  int mods [2] = '{8, 6};
  int mq   [2];
  int mw   [2];
  int mh   [2];

  always #5 clk = ~clk;

  con_updown_n_if #(.W(3)) ifa ();
  con_updown_n_if #(.W(3)) ifb ();

  assign ifa.x = x;  assign ifa.en = en; assign ifa.ld = ld;
  assign ifa.os = os; assign ifa.d = d;
  assign ifb.x = x;  assign ifb.en = en; assign ifb.ld = ld;
  assign ifb.os = os; assign ifb.d = d;

  con_updown_n #(.W(3), .MODULO(8)) dut_a (.clk(clk), .res(res), .bus(ifa.slave));
  con_updown_n #(.W(3), .MODULO(6)) dut_b (.clk(clk), .res(res), .bus(ifb.slave));

  // Apply one edge of stimulus and advance the reference model alongside.
  task automatic step(input bit r_i, input bit ld_i, input bit en_i,
                      input bit x_i, input bit os_i, input int d_i);
    bit term;
    res = r_i; ld = ld_i; en = en_i; x = x_i; os = os_i; d = 3'(d_i);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r_i) begin
        mq[k] = 0; mh[k] = 0; mw[k] = 0;
      end else if (ld_i) begin
        mq[k] = (d_i < mods[k]) ? d_i : mods[k] - 1;
        mh[k] = 0; mw[k] = 0;
      end else if (en_i && mh[k] == 0) begin
        term  = x_i ? (mq[k] + 1 == mods[k]) : (mq[k] == 0);
        mw[k] = term ? 1 : 0;
        if (term && os_i) mh[k] = 1;
        else mq[k] = x_i ? (mq[k] + 1) % mods[k] : (mq[k] + mods[k] - 1) % mods[k];
      end else begin
        mw[k] = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 1, 1, 0, 5);
    checks++;
    if (ifa.q !== 3'd0 || ifa.wrap !== 1'b0 || ifa.halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: q=%0d wrap=%b halted=%b expected 0/0/0", ifa.q, ifa.wrap, ifa.halted);
    end
    checks++;
    if (ifa.tc !== 1'b0) begin
      errors++; $display("FAIL reset_tc_up: tc=%b expected 0", ifa.tc);
    end
    x = 1'b0; #1;
    checks++;
    if (ifa.tc !== 1'b1 || ifb.tc !== 1'b1) begin
      errors++; $display("FAIL reset_tc_down: tc=%b/%b expected 1/1", ifa.tc, ifb.tc);
    end
  endtask

  task automatic test_up_freerun();
    int seq [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 1, 1, 0, 0);
      checks++;
      if (ifa.q !== 3'(seq[i]) || ifa.wrap !== (i == 7)) begin
        errors++;
        $display("FAIL up_freerun[%0d]: q=%0d wrap=%b expected %0d/%b", i, ifa.q, ifa.wrap, seq[i], i == 7);
      end
    end
  endtask

  task automatic test_down_freerun();
    int seq [7] = '{5, 4, 3, 2, 1, 0, 5};
    bit wr  [7] = '{1, 0, 0, 0, 0, 0, 1};
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, 0, 0, 0);
      checks++;
      if (ifb.q !== 3'(seq[i]) || ifb.wrap !== wr[i]) begin
        errors++;
        $display("FAIL down_mod6[%0d]: q=%0d wrap=%b expected %0d/%b", i, ifb.q, ifb.wrap, seq[i], wr[i]);
      end
    end
  endtask

  task automatic test_oneshot();
    step(1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, 1, 1, 0);
      checks++;
      if (ifa.q !== 3'(i + 1) || ifa.wrap !== 1'b0 || ifa.halted !== 1'b0) begin
        errors++;
        $display("FAIL oneshot_count[%0d]: q=%0d wrap=%b halted=%b expected %0d/0/0", i, ifa.q, ifa.wrap, ifa.halted, i + 1);
      end
    end
    step(0, 0, 1, 1, 1, 0);
    checks++;
    if (ifa.q !== 3'd7 || ifa.wrap !== 1'b1 || ifa.halted !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_term: q=%0d wrap=%b halted=%b expected 7/1/1", ifa.q, ifa.wrap, ifa.halted);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, i[0], i[1], 0);
      checks++;
      if (ifa.q !== 3'd7 || ifa.wrap !== 1'b0 || ifa.halted !== 1'b1) begin
        errors++;
        $display("FAIL oneshot_hold[%0d]: q=%0d wrap=%b halted=%b expected 7/0/1", i, ifa.q, ifa.wrap, ifa.halted);
      end
    end
    step(0, 1, 0, 1, 1, 2);
    checks++;
    if (ifa.q !== 3'd2 || ifa.halted !== 1'b0 || ifa.wrap !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_reload: q=%0d halted=%b wrap=%b expected 2/0/0", ifa.q, ifa.halted, ifa.wrap);
    end
  endtask

  task automatic test_load();
    step(1, 0, 0, 1, 0, 0);
    step(0, 1, 1, 1, 0, 7);
    checks++;
    if (ifb.q !== 3'd5 || ifa.q !== 3'd7 || ifb.wrap !== 1'b0) begin
      errors++;
      $display("FAIL load_clamp: q=%0d/%0d wrap=%b expected 5/7/0", ifb.q, ifa.q, ifb.wrap);
    end
    step(0, 1, 0, 0, 0, 3);
    step(0, 0, 1, 0, 0, 0);
    checks++;
    if (ifa.q !== 3'd2 || ifb.q !== 3'd2) begin
      errors++;
      $display("FAIL load_then_down: q=%0d/%0d expected 2/2", ifa.q, ifb.q);
    end
  endtask

  task automatic test_reset_override();
    step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0, 0);
    checks++;
    if (ifa.q !== 3'd4) begin
      errors++; $display("FAIL ovr_pre: q=%0d expected 4", ifa.q);
    end
    step(1, 0, 1, 1, 0, 0);
    checks++;
    if (ifa.q !== 3'd0 || ifa.halted !== 1'b0 || ifa.wrap !== 1'b0) begin
      errors++;
      $display("FAIL ovr_count: q=%0d halted=%b wrap=%b expected 0/0/0", ifa.q, ifa.halted, ifa.wrap);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 1, 0);
    checks++;
    if (ifa.halted !== 1'b1 || ifa.q !== 3'd7) begin
      errors++; $display("FAIL ovr_halt: q=%0d halted=%b expected 7/1", ifa.q, ifa.halted);
    end
    step(1, 1, 1, 1, 1, 5);
    checks++;
    if (ifa.q !== 3'd0 || ifa.halted !== 1'b0 || ifa.wrap !== 1'b0) begin
      errors++;
      $display("FAIL ovr_halt_ld: q=%0d halted=%b wrap=%b expected 0/0/0", ifa.q, ifa.halted, ifa.wrap);
    end
  endtask

`ifdef CON_GRAY_OUT_EN
  task automatic test_gray();
    int gseq [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ifa.gq !== 3'(gseq[i])) begin
        errors++; $display("FAIL gray[%0d]: gq=%0d expected %0d", i, ifa.gq, gseq[i]);
      end
      step(0, 0, 1, 1, 0, 0);
    end
  endtask
`endif

  task automatic test_random();
    logic [2:0] aq;
    logic       aw, ah, at;
    int         etc;
    step(1, 0, 0, 1, 0, 0);
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(31) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
           1'($urandom), 1'($urandom_range(3) == 0), int'($urandom_range(7)));
      for (int k = 0; k < 2; k++) begin
        aq  = (k == 0) ? ifa.q      : ifb.q;
        aw  = (k == 0) ? ifa.wrap   : ifb.wrap;
        ah  = (k == 0) ? ifa.halted : ifb.halted;
        at  = (k == 0) ? ifa.tc     : ifb.tc;
        etc = x ? (mq[k] == mods[k] - 1) : (mq[k] == 0);
        checks++;
        if (aq !== 3'(mq[k]) || aw !== 1'(mw[k]) || ah !== 1'(mh[k]) || at !== 1'(etc)) begin
          errors++;
          $display("FAIL random[%0d] mod%0d: q=%0d wrap=%b halted=%b tc=%b expected %0d/%0d/%0d/%0d",
                   n, mods[k], aq, aw, ah, at, mq[k], mw[k], mh[k], etc);
        end
      end
    end
  endtask

  initial begin
    res = 1'b1; x = 1'b1; en = 1'b0; ld = 1'b0; os = 1'b0; d = '0;
    for (int k = 0; k < 2; k++) begin
      mq[k] = 0; mw[k] = 0; mh[k] = 0;
    end
    @(negedge clk);
    test_reset();
    test_up_freerun();
    test_down_freerun();
    test_oneshot();
    test_load();
    test_reset_override();
`ifdef CON_GRAY_OUT_EN
    test_gray();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/con_updown_n.md
CON_UPDOWN_N -- requirements
Module: con_updown_n

Interface
REQ-001 SHALL have parameter W, default 3, counter width in bits (W >= 2).
REQ-002 SHALL have parameter MODULO, default 2**W, count range 0..MODULO-1 (2 <= MODULO <= 2**W).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port res  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port x  input  1  direction: 1 = up, 0 = down.
REQ-006 SHALL have port en  input  1  count enable.
REQ-007 SHALL have port ld  input  1  synchronous load strobe.
REQ-008 SHALL have port os  input  1  mode: 1 = one-shot, 0 = free-run.
REQ-009 SHALL have port d  input  W  load value.
REQ-010 SHALL have port q  output  W  registered count.
REQ-011 SHALL have port tc  output  1  combinational terminal count: (x & q==MODULO-1) | (~x & q==0).
REQ-012 SHALL have port wrap  output  1  registered one-cycle pulse marking a terminal event.
REQ-013 SHALL have port halted  output  1  registered; high while in state HALT.

Function
REQ-014 SHALL apply the priority res > ld > en on every edge.
REQ-015 SHALL implement a two-state FSM {RUN, HALT}; halted = (state == HALT).
REQ-016 On ld: q <= d if d < MODULO, else MODULO-1; state <= RUN; wrap <= 0; any en in the same cycle is ignored.
REQ-017 In RUN with en=1, x=1, and q < MODULO-1: q <= q+1.
REQ-018 In RUN with en=1, x=0, and q > 0: q <= q-1.
REQ-019 In RUN with en=1, tc=1, and os=0: q wraps (up: to 0; down: to MODULO-1) and wrap <= 1.
REQ-020 In RUN with en=1, tc=1, and os=1: q holds, state <= HALT, and wrap <= 1.
REQ-021 In HALT: q holds regardless of en, x, or os; the FSM leaves HALT only on ld or res.
REQ-022 wrap SHALL be high for exactly the cycle after the terminal edge, and low in all other cycles, including back-to-back enabled cycles without a terminal event.
REQ-023 A change of x or os SHALL take effect on the next enabled edge; tc SHALL follow x combinationally in the same cycle.
REQ-024 With en=0 and ld=0: q, state, and halted SHALL hold, and wrap SHALL be 0.
REQ-025 The next-state arithmetic SHALL be computed at W+1 bits, so no intermediate value outside 0..MODULO-1 ever reaches q.

Reset
REQ-026 While res=1 at an edge, the block SHALL set q=0, wrap=0, state=RUN, and halted=0; tc then equals ~x.
REQ-027 A reset in the middle of a count, in HALT, or coincident with ld or en SHALL override them all.

Configuration
REQ-028 Macro CON_GRAY_OUT_EN, when defined, SHALL add output gq (W bits) = q ^ (q >> 1), valid only when MODULO == 2**W.
REQ-029 Without CON_GRAY_OUT_EN, gq and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 Shared package con_pkg SHALL hold the state enum (RUN, HALT) and the default width constant CON_W_DEF = 3.
REQ-031 The Gray encoder SHALL be sub-module con_gray_enc, instantiated only under CON_GRAY_OUT_EN; all counting logic SHALL stay in con_updown_n.

Verification
REQ-032 W=3, MODULO=8, os=0, x=1, en=1 from reset -> q = 0..7, then 0; wrap high only in the cycle showing q=0 after 7.
REQ-033 W=3, MODULO=6, x=0, en=1 from reset -> q = 0,5,4,3,2,1,0,5; wrap pulses after each 0->5 edge.
REQ-034 os=1, x=1, MODULO=8, count from reset -> q stops at 7, halted=1, wrap pulses once; en held for 5 cycles leaves q=7; ld with d=2 -> q=2, halted=0.
REQ-035 ld=1, en=1, d=7, MODULO=6 -> q=5 (clamped), no count in that cycle; ld with d=3 and x=0 followed by en -> q=2.
REQ-036 res asserted while q=4 and en=1, then again during HALT with ld=1 -> q=0, halted=0, wrap=0 on the next cycle each time.
REQ-037 With CON_GRAY_OUT_EN, W=3, up-count 0..7 -> gq = 0,1,3,2,6,7,5,4; the same bench without the macro compiles and passes REQ-032 to REQ-036.
